// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC conversion sequencer.
// - seq_state_e : sequencer FSM states
// - RECOVER_CYC : cycles the loop enable is held low after a timeout
// - DLY_W/PW_W  : widths of the loop delay codes and the edge-detect pulse-width code
package adc_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StTrig,
    StWait,
    StGap,
    StRecover
  } seq_state_e;

  localparam int unsigned RECOVER_CYC = 4;
  localparam int unsigned DLY_W       = 5;
  localparam int unsigned PW_W        = 6;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adc_seq_done_sync.sv
// End-of-conversion synchronizer: two-flop synchronizer into the clk domain, followed by a
// registered rising-edge detector. done_evt is a one-cycle pulse three clk cycles after the
// async level rises.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset (clears the synchronizer)
//   async_in  in   end-of-conversion level from the clk_dig_out domain
//   done_evt  out  one-cycle done pulse
module adc_seq_done_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic done_evt
);

  // [0],[1] synchronize; [2] holds the previous synchronized value for edge detection
  logic [2:0] sync_q;
  logic       evt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      evt_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
      evt_q  <= sync_q[1] & ~sync_q[2];
    end
  end

  assign done_evt = evt_q;

endmodule

// File: rtl/adc_conv_sequencer.sv
// ADC conversion sequencer: gates the SAR clock generator's loop enable, issues conversion
// triggers, shadows the delay settings so they only change between conversions, supports
// single-shot and periodic operation and recovers a stalled loop by timeout.
// Optional feature: define ADC_SEQ_STATS_EN to make conv_cnt/tmo_cnt live counters;
// otherwise both are tied to 0 and no counter flops exist.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cfg_enable, cfg_interval        periodic mode enable and idle gap between conversions
//   single_shot_req                 one-cycle request for one conversion (ignored when busy)
//   cfg_dly_en, cfg_dly1..4         delay settings, shadowed on entry to ARM from IDLE/GAP
//   conv_done_async                 end-of-conversion level (async), rising edge = done
//   ena_out, start_conv_out         loop enable and trigger to the clock generator
//   enable_dlycontrol_out,
//   dlycontrol1..4_out              shadowed delay settings
//   busy                            high whenever the sequencer is not idle
//   timeout_pulse                   one-cycle pulse on a WAIT timeout
//   conv_cnt, tmo_cnt               completed conversions / timeouts
module adc_conv_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned INTERVAL_W = 16,
  parameter int unsigned TMO_CYC    = 255,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned START_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_enable,
  input  logic [INTERVAL_W-1:0] cfg_interval,
  input  logic                  single_shot_req,
  input  logic                  cfg_dly_en,
  input  logic [DLY_W-1:0]      cfg_dly1,
  input  logic [DLY_W-1:0]      cfg_dly2,
  input  logic [DLY_W-1:0]      cfg_dly3,
  input  logic [PW_W-1:0]       cfg_dly4,
  input  logic                  conv_done_async,
  output logic                  ena_out,
  output logic                  start_conv_out,
  output logic                  enable_dlycontrol_out,
  output logic [DLY_W-1:0]      dlycontrol1_out,
  output logic [DLY_W-1:0]      dlycontrol2_out,
  output logic [DLY_W-1:0]      dlycontrol3_out,
  output logic [PW_W-1:0]       dlycontrol4_out,
  output logic                  busy,
  output logic                  timeout_pulse,
  output logic [15:0]           conv_cnt,
  output logic [7:0]            tmo_cnt
);

  // One phase counter is shared by ARM, TRIG, WAIT and RECOVER; size it for the longest.
  localparam int unsigned CntMax = max_u(max_u(TMO_CYC, SETTLE_CYC),
                                         max_u(START_CYC, RECOVER_CYC));
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE_CYC - 1);
  localparam logic [CntW-1:0] StartLast   = CntW'(START_CYC - 1);
  localparam logic [CntW-1:0] TmoLast     = CntW'(TMO_CYC - 1);
  localparam logic [CntW-1:0] RecoverLast = CntW'(RECOVER_CYC - 1);

  seq_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [INTERVAL_W-1:0] gap_q, gap_d;
  logic                  periodic_q, periodic_d;
  logic                  ena_q, ena_d;
  logic                  start_q, start_d;
  logic                  tmo_q, tmo_evt;
  logic                  load_shadow;
  logic                  conv_inc;
  logic                  done_evt;

  logic                  dly_en_q;
  logic [DLY_W-1:0]      dly1_q, dly2_q, dly3_q;
  logic [PW_W-1:0]       dly4_q;

  adc_seq_done_sync u_done_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (conv_done_async),
    .done_evt (done_evt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    gap_d       = gap_q;
    periodic_d  = periodic_q;
    load_shadow = 1'b0;
    conv_inc    = 1'b0;
    tmo_evt     = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (cfg_enable || single_shot_req) begin
          state_d     = StArm;
          periodic_d  = cfg_enable;
          load_shadow = 1'b1;
        end
      end

      StArm: begin
        if (cnt_q == SettleLast) begin
          state_d = StTrig;
          cnt_d   = '0;
        end
      end

      // done_evt is not looked at here: a done before the trigger ends is spurious
      StTrig: begin
        if (cnt_q == StartLast) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end

      // Checking done first makes done win over a coincident timeout
      StWait: begin
        if (done_evt) begin
          conv_inc = 1'b1;
          cnt_d    = '0;
          if (periodic_q && cfg_enable) begin
            state_d = StGap;
            gap_d   = cfg_interval;
          end else begin
            state_d = StIdle;
          end
        end else if (cnt_q == TmoLast) begin
          tmo_evt = 1'b1;
          state_d = StRecover;
          cnt_d   = '0;
        end
      end

      // An interval of 0 or 1 both give a single GAP cycle
      StGap: begin
        cnt_d = '0;
        if (!cfg_enable) begin
          state_d = StIdle;
        end else if (gap_q <= INTERVAL_W'(1)) begin
          state_d     = StArm;
          load_shadow = 1'b1;
        end else begin
          gap_d = gap_q - INTERVAL_W'(1);
        end
      end

      // Re-arming from here keeps the current shadowed settings
      StRecover: begin
        if (cnt_q == RecoverLast) begin
          cnt_d = '0;
          if (cfg_enable) begin
            state_d    = StArm;
            periodic_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Outputs registered from the next state so the clock generator sees glitch-free levels
    ena_d   = (state_d == StArm) || (state_d == StTrig) ||
              (state_d == StWait) || (state_d == StGap);
    start_d = (state_d == StTrig);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      gap_q      <= '0;
      periodic_q <= 1'b0;
      ena_q      <= 1'b0;
      start_q    <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      periodic_q <= periodic_d;
      ena_q      <= ena_d;
      start_q    <= start_d;
      tmo_q      <= tmo_evt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_en_q <= 1'b0;
      dly1_q   <= '0;
      dly2_q   <= '0;
      dly3_q   <= '0;
      dly4_q   <= '0;
    end else if (load_shadow) begin
      dly_en_q <= cfg_dly_en;
      dly1_q   <= cfg_dly1;
      dly2_q   <= cfg_dly2;
      dly3_q   <= cfg_dly3;
      dly4_q   <= cfg_dly4;
    end
  end

`ifdef ADC_SEQ_STATS_EN
  logic [15:0] conv_cnt_q;
  logic [7:0]  tmo_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      if (conv_inc) conv_cnt_q <= conv_cnt_q + 16'd1;
      if (tmo_evt)  tmo_cnt_q  <= tmo_cnt_q + 8'd1;
    end
  end

  assign conv_cnt = conv_cnt_q;
  assign tmo_cnt  = tmo_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = conv_inc;
  assign conv_cnt     = '0;
  assign tmo_cnt      = '0;
`endif

  assign ena_out               = ena_q;
  assign start_conv_out        = start_q;
  assign timeout_pulse         = tmo_q;
  assign busy                  = (state_q != StIdle);
  assign enable_dlycontrol_out = dly_en_q;
  assign dlycontrol1_out       = dly1_q;
  assign dlycontrol2_out       = dly2_q;
  assign dlycontrol3_out       = dly3_q;
  assign dlycontrol4_out       = dly4_q;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Self-checking bench for adc_conv_sequencer. Inputs are driven and outputs sampled 1 time
// unit after each rising clock edge; "cycle n" is the interval following rising edge n.
// Expected timing comes from the sequencing rules: ARM lasts SETTLE_CYC, TRIG START_CYC,
// done is seen 3 cycles after the async edge and acted on at the following edge, GAP lasts
// max(interval,1), RECOVER 4, and a WAIT with no done ends after TMO_CYC cycles.
module tb_adc_conv_sequencer;

  localparam int SETTLE = 4;
  localparam int STARTW = 2;
  localparam int TMO    = 255;
  localparam int RECOV  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [15:0] cfg_interval = '0;
  logic        single_shot_req = 1'b0;
  logic        cfg_dly_en = 1'b0;
  logic [4:0]  cfg_dly1 = '0, cfg_dly2 = '0, cfg_dly3 = '0;
  logic [5:0]  cfg_dly4 = '0;
  logic        conv_done_async = 1'b0;
  logic        ena_out, start_conv_out, enable_dlycontrol_out, busy, timeout_pulse;
  logic [4:0]  dlycontrol1_out, dlycontrol2_out, dlycontrol3_out;
  logic [5:0]  dlycontrol4_out;
  logic [15:0] conv_cnt;
  logic [7:0]  tmo_cnt;

  int cyc = 0;
  int checks = 0;
  int passed = 0;
  int n_conv = 0;
  int n_tmo = 0;

  adc_conv_sequencer dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .cfg_enable            (cfg_enable),
    .cfg_interval          (cfg_interval),
    .single_shot_req       (single_shot_req),
    .cfg_dly_en            (cfg_dly_en),
    .cfg_dly1              (cfg_dly1),
    .cfg_dly2              (cfg_dly2),
    .cfg_dly3              (cfg_dly3),
    .cfg_dly4              (cfg_dly4),
    .conv_done_async       (conv_done_async),
    .ena_out               (ena_out),
    .start_conv_out        (start_conv_out),
    .enable_dlycontrol_out (enable_dlycontrol_out),
    .dlycontrol1_out       (dlycontrol1_out),
    .dlycontrol2_out       (dlycontrol2_out),
    .dlycontrol3_out       (dlycontrol3_out),
    .dlycontrol4_out       (dlycontrol4_out),
    .busy                  (busy),
    .timeout_pulse         (timeout_pulse),
    .conv_cnt              (conv_cnt),
    .tmo_cnt               (tmo_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Counter values the statistics outputs should show for n events
  function automatic logic [31:0] exp_stat(input int n, input int w);
`ifdef ADC_SEQ_STATS_EN
    return 32'(n % (1 << w));
`else
    return 32'(n * 0 + w * 0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  // Returns the first cycle at which start_conv_out is seen high, or -1 on budget expiry
  task automatic wait_start(input string tag, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget && t < 0; i++) begin
      if (start_conv_out === 1'b1) t = cyc;
      else tick();
    end
    chk({tag, "_seen"}, 32'(t >= 0), 1);
  endtask

  // Raise the async done edge lat cycles after WAIT entry (t+START); returns at edge+2
  task automatic do_conv(input int t, input int lat);
    wait_until(t + STARTW + lat);
    conv_done_async = 1'b1;
    tick();
    tick();
    conv_done_async = 1'b0;
  endtask

  task automatic run_periodic(input int iv, input int n, input bit shadow_chk);
    int t, tn, lat, c, e, gap, hi;
    logic [4:0] d2, d3;
    logic [5:0] d4;
    d2 = '0; d3 = '0; d4 = '0;
    cfg_interval = 16'(iv);
    cfg_enable   = 1'b1;
    e = cyc;
    gap = (iv == 0) ? 1 : iv;
    wait_start("per_first", 20, t);
    chk("per_first_t", 32'(t), 32'(e + 1 + SETTLE));
    if (shadow_chk) begin
      chk("shadow_dly1_init", 32'(dlycontrol1_out), 3);
      chk("shadow_en_init", 32'(enable_dlycontrol_out), 1);
    end
    for (int k = 0; k < n; k++) begin
      lat = $urandom_range(2, 30);
      wait_until(t + STARTW + 1);
      if (shadow_chk && k == 0) begin
        chk("shadow_hold_wait", 32'(dlycontrol1_out), 3);
        d2 = 5'($urandom); d3 = 5'($urandom); d4 = 6'($urandom);
        cfg_dly1 = 5'd17; cfg_dly2 = d2; cfg_dly3 = d3; cfg_dly4 = d4;
      end
      if (k == n - 1) begin
        // Last conversion: disable during WAIT and try a single shot while busy
        cfg_enable      = 1'b0;
        single_shot_req = 1'b1;
        tick();
        single_shot_req = 1'b0;
      end
      do_conv(t, lat);
      n_conv++;
      c = t + STARTW + lat;
      if (shadow_chk && k == 0) chk("shadow_hold_late", 32'(dlycontrol1_out), 3);
      if (k < n - 1) begin
        wait_start("per_next", lat + gap + 20, tn);
        chk("per_spacing", 32'(tn - t), 32'(lat + 3 + 1 + gap + SETTLE + STARTW));
        if (shadow_chk && k == 0) begin
          chk("shadow_dly1_new", 32'(dlycontrol1_out), 17);
          chk("shadow_dly2_new", 32'(dlycontrol2_out), 32'(d2));
          chk("shadow_dly3_new", 32'(dlycontrol3_out), 32'(d3));
          chk("shadow_dly4_new", 32'(dlycontrol4_out), 32'(d4));
        end
        t = tn;
      end else begin
        wait_until(c + 3);
        chk("last_busy_held", 32'(busy), 1);
        tick();
        chk("last_busy_drop", 32'(busy), 0);
        chk("per_conv_cnt", 32'(conv_cnt), exp_stat(n_conv, 16));
        hi = 0;
        repeat (60) begin
          tick();
          if (start_conv_out !== 1'b0 || busy !== 1'b0) hi++;
        end
        chk("no_retrigger", 32'(hi), 0);
      end
    end
  endtask

  initial begin
    int t, t2, w, c;

    // Reset state
    #1;
    chk("rst_ena", 32'(ena_out), 0);
    chk("rst_start", 32'(start_conv_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tmo", 32'(timeout_pulse), 0);
    chk("rst_dly1", 32'(dlycontrol1_out), 0);
    chk("rst_dly4", 32'(dlycontrol4_out), 0);
    chk("rst_conv_cnt", 32'(conv_cnt), 0);
    wait_until(2);
    rst_n = 1'b1;

    // Single shot requested in cycle 10, done edge 20 cycles after the trigger
    cfg_dly1 = 5'd3; cfg_dly_en = 1'b1;
    wait_until(10);
    chk("ss_ena_before", 32'(ena_out), 0);
    single_shot_req = 1'b1;
    tick();
    single_shot_req = 1'b0;
    chk("ss_ena_rise", 32'(ena_out), 1);
    chk("ss_busy", 32'(busy), 1);
    wait_start("ss", 20, t);
    chk("ss_start_t", 32'(t), 15);
    tick();
    chk("ss_start_2nd", 32'(start_conv_out), 1);
    tick();
    chk("ss_start_end", 32'(start_conv_out), 0);
    chk("ss_ena_wait", 32'(ena_out), 1);
    do_conv(t, 20 - STARTW);
    n_conv++;
    c = t + 20;
    wait_until(c + 3);
    chk("ss_busy_held", 32'(busy), 1);
    tick();
    chk("ss_busy_drop", 32'(busy), 0);
    chk("ss_ena_drop", 32'(ena_out), 0);
    chk("ss_conv_cnt", 32'(conv_cnt), exp_stat(n_conv, 16));
    repeat (5) tick();

    // Periodic with interval 10 and shadow-update checks, then interval 0
    run_periodic(10, 5, 1'b1);
    run_periodic(0, 3, 1'b0);

    // Timeout in periodic mode: loop never reports done
    cfg_interval = 16'(4);
    cfg_enable   = 1'b1;
    wait_start("tmo", 20, t);
    w = t + STARTW;
    wait_until(w + TMO - 1);
    chk("tmo_not_early", 32'(timeout_pulse), 0);
    chk("tmo_ena_wait", 32'(ena_out), 1);
    tick();
    n_tmo++;
    chk("tmo_pulse", 32'(timeout_pulse), 1);
    chk("tmo_ena_low", 32'(ena_out), 0);
    tick();
    chk("tmo_pulse_one", 32'(timeout_pulse), 0);
    wait_until(w + TMO + RECOV - 1);
    chk("tmo_ena_low_end", 32'(ena_out), 0);
    chk("tmo_busy_rec", 32'(busy), 1);
    tick();
    chk("tmo_rearm", 32'(ena_out), 1);
    chk("tmo_cnt", 32'(tmo_cnt), exp_stat(n_tmo, 8));
    cfg_enable = 1'b0;
    wait_start("tmo_retrig", 10, t2);
    chk("tmo_retrig_t", 32'(t2), 32'(w + TMO + RECOV + SETTLE));
    do_conv(t2, 5);
    n_conv++;
    wait_until(t2 + STARTW + 5 + 4);
    chk("tmo_final_idle", 32'(busy), 0);
    chk("tmo_conv_cnt", 32'(conv_cnt), exp_stat(n_conv, 16));
    repeat (5) tick();

    // Reset asserted during TRIG
    cfg_dly1 = 5'd9; cfg_dly_en = 1'b1; cfg_dly4 = 6'd33;
    single_shot_req = 1'b1;
    tick();
    single_shot_req = 1'b0;
    wait_start("rst_trig", 20, t);
    chk("pre_rst_dly1", 32'(dlycontrol1_out), 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_start", 32'(start_conv_out), 0);
    chk("mid_rst_ena", 32'(ena_out), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_ena", 32'(ena_out), 0);
    chk("post_rst_dly1", 32'(dlycontrol1_out), 0);
    chk("post_rst_dly4", 32'(dlycontrol4_out), 0);
    chk("post_rst_dly_en", 32'(enable_dlycontrol_out), 0);
    chk("post_rst_conv_cnt", 32'(conv_cnt), 0);
    chk("post_rst_tmo_cnt", 32'(tmo_cnt), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
